// File: rtl/combat_sequencer.sv
// combat_sequencer: turn-based encounter controller for the dungeon engine.
// Takes over from the movement datapath when the player steps onto an enemy
// tile, sequences player strike / enemy strike / run roll turns, owns both HP
// counters and reports the outcome of each encounter back to the engine.

module combat_sequencer #(
  parameter int unsigned PLAYER_MAX_HP = 100,
  parameter int unsigned ENEMY_MAX_HP  = 50,
  parameter int unsigned PLAYER_DMG    = 10,
  parameter int unsigned ENEMY_DMG     = 8,
  parameter int unsigned DMG_RAND_EN   = 1,
  parameter int unsigned RUN_THRESH    = 1,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enc_start,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_code,
  output logic        cmd_ready,
  input  logic        godmode,
  output logic        in_combat,
  output logic        move_lock,
  output logic [15:0] player_hp,
  output logic [15:0] enemy_hp,
  output logic        run_failed,
  output logic        run_dir_valid,
  output logic [1:0]  run_dir,
  output logic        result_valid,
  output logic [1:0]  result,
  output logic        illegal_cmd,
  output logic        dead
);

  localparam logic [15:0] PLAYER_MAX_HP_W = 16'(PLAYER_MAX_HP);
  localparam logic [15:0] ENEMY_MAX_HP_W  = 16'(ENEMY_MAX_HP);
  localparam logic [15:0] PLAYER_DMG_W    = 16'(PLAYER_DMG);
  localparam logic [15:0] ENEMY_DMG_W     = 16'(ENEMY_DMG);

  localparam logic [15:0] CMD_ATTACK = 16'd5;
  localparam logic [15:0] CMD_RUN    = 16'd6;

  localparam logic [1:0] RES_WIN  = 2'd1;
  localparam logic [1:0] RES_FLED = 2'd2;
  localparam logic [1:0] RES_DIED = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CMD,
    S_P_HIT,
    S_E_HIT,
    S_RUN_ROLL,
    S_DEAD
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [15:0] player_hp_q, player_hp_d;
  logic [15:0] enemy_hp_q, enemy_hp_d;
  logic        in_combat_q, in_combat_d;
  logic        move_lock_q, move_lock_d;
  logic        dead_q, dead_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        run_failed_q, run_failed_d;
  logic        run_dir_valid_q, run_dir_valid_d;
  logic [1:0]  run_dir_q, run_dir_d;
  logic        result_valid_q, result_valid_d;
  logic [1:0]  result_q, result_d;
  logic        illegal_cmd_q, illegal_cmd_d;

  // Random component of a damage roll, drawn from the current LFSR value.
  logic [15:0] roll;
  logic [15:0] player_dmg;
  logic [15:0] enemy_dmg;
  logic        run_ok;

  // HP never wraps: a hit larger than the remaining HP leaves exactly zero.
  function automatic logic [15:0] sat_sub(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? (a - b) : 16'd0;
  endfunction

  // Damage and run-roll inputs sampled from the LFSR in the active roll cycle.
  always_comb begin
    roll       = (DMG_RAND_EN != 0) ? {14'd0, lfsr_q[1:0]} : 16'd0;
    player_dmg = PLAYER_DMG_W + roll;
    enemy_dmg  = ENEMY_DMG_W + roll;
    run_ok     = (32'(lfsr_q[3:2]) >= RUN_THRESH);
  end

  // Next-state and next-output logic for the encounter sequencer.
  always_comb begin
    // NOTE: every _d starts from a hold or idle default so that no path through
    // the case statement leaves a signal unassigned and infers a latch.
    state_d         = state_q;
    lfsr_d          = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    player_hp_d     = player_hp_q;
    enemy_hp_d      = enemy_hp_q;
    in_combat_d     = in_combat_q;
    dead_d          = dead_q;
    run_dir_d       = run_dir_q;
    result_d        = result_q;
    run_failed_d    = 1'b0;
    run_dir_valid_d = 1'b0;
    result_valid_d  = 1'b0;
    illegal_cmd_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (enc_start) begin
          enemy_hp_d  = ENEMY_MAX_HP_W;
          in_combat_d = 1'b1;
          state_d     = S_WAIT_CMD;
        end
      end

      S_WAIT_CMD: begin
        // cmd_ready is high throughout this state, so cmd_valid alone is a handshake.
        if (cmd_valid) begin
          if (cmd_code == CMD_ATTACK) begin
            state_d = S_P_HIT;
          end else if (cmd_code == CMD_RUN) begin
            state_d = S_RUN_ROLL;
          end else begin
            illegal_cmd_d = 1'b1;
          end
        end
      end

      S_P_HIT: begin
        enemy_hp_d = sat_sub(enemy_hp_q, player_dmg);
        if (enemy_hp_d == 16'd0) begin
          result_d       = RES_WIN;
          result_valid_d = 1'b1;
          in_combat_d    = 1'b0;
          state_d        = S_IDLE;
        end else begin
          state_d = S_E_HIT;
        end
      end

      S_E_HIT: begin
        if (!godmode) begin
          player_hp_d = sat_sub(player_hp_q, enemy_dmg);
        end
        if (player_hp_d == 16'd0) begin
          result_d       = RES_DIED;
          result_valid_d = 1'b1;
          dead_d         = 1'b1;
          in_combat_d    = 1'b0;
          state_d        = S_DEAD;
        end else begin
          state_d = S_WAIT_CMD;
        end
      end

      S_RUN_ROLL: begin
        if (run_ok) begin
          run_dir_d       = lfsr_q[5:4];
          run_dir_valid_d = 1'b1;
          result_d        = RES_FLED;
          result_valid_d  = 1'b1;
          in_combat_d     = 1'b0;
          enemy_hp_d      = 16'd0;
          state_d         = S_IDLE;
        end else begin
          // A failed escape hands the enemy a free strike.
          run_failed_d = 1'b1;
          state_d      = S_E_HIT;
        end
      end

      S_DEAD: begin
        state_d = S_DEAD;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Registered versions of the derived flags keep every output glitch-free.
    cmd_ready_d = (state_d == S_WAIT_CMD);
    move_lock_d = in_combat_d | dead_d;
  end

  // State, LFSR, HP counters and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state_q         <= S_IDLE;
      lfsr_q          <= LFSR_SEED;
      player_hp_q     <= PLAYER_MAX_HP_W;
      enemy_hp_q      <= 16'd0;
      in_combat_q     <= 1'b0;
      move_lock_q     <= 1'b0;
      dead_q          <= 1'b0;
      cmd_ready_q     <= 1'b0;
      run_failed_q    <= 1'b0;
      run_dir_valid_q <= 1'b0;
      run_dir_q       <= 2'd0;
      result_valid_q  <= 1'b0;
      result_q        <= 2'd0;
      illegal_cmd_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      lfsr_q          <= lfsr_d;
      player_hp_q     <= player_hp_d;
      enemy_hp_q      <= enemy_hp_d;
      in_combat_q     <= in_combat_d;
      move_lock_q     <= move_lock_d;
      dead_q          <= dead_d;
      cmd_ready_q     <= cmd_ready_d;
      run_failed_q    <= run_failed_d;
      run_dir_valid_q <= run_dir_valid_d;
      run_dir_q       <= run_dir_d;
      result_valid_q  <= result_valid_d;
      result_q        <= result_d;
      illegal_cmd_q   <= illegal_cmd_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign in_combat     = in_combat_q;
  assign move_lock     = move_lock_q;
  assign player_hp     = player_hp_q;
  assign enemy_hp      = enemy_hp_q;
  assign run_failed    = run_failed_q;
  assign run_dir_valid = run_dir_valid_q;
  assign run_dir       = run_dir_q;
  assign result_valid  = result_valid_q;
  assign result        = result_q;
  assign illegal_cmd   = illegal_cmd_q;
  assign dead          = dead_q;

endmodule

// File: tb/tb_combat_sequencer.sv
// tb_combat_sequencer: four differently configured combat_sequencer instances
// share one clock and reset. A transaction-level model (HP integers plus a
// short queue of pending turn actions) predicts every output each cycle, and
// directed steps add hand-computed literal expectations.

module tb_combat_sequencer;

  localparam int ND = 4;

  // Per-instance configuration:
  //   0: P100 E20 fixed damage        1: P16 E50 fixed damage
  //   2: P100 E50 random, always flee 3: P100 E50 fixed, never flee
  function automatic int cfg_pmax(input int d);
    return (d == 1) ? 16 : 100;
  endfunction
  function automatic int cfg_emax(input int d);
    return (d == 0) ? 20 : 50;
  endfunction
  function automatic int cfg_rand(input int d);
    return (d == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_thresh(input int d);
    return (d == 2) ? 0 : ((d == 3) ? 4 : 1);
  endfunction

  localparam int PDMG = 10;
  localparam int EDMG = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enc_start     [ND];
  logic        cmd_valid     [ND];
  logic [15:0] cmd_code      [ND];
  logic        godmode       [ND];
  logic        cmd_ready     [ND];
  logic        in_combat     [ND];
  logic        move_lock     [ND];
  logic [15:0] player_hp     [ND];
  logic [15:0] enemy_hp      [ND];
  logic        run_failed    [ND];
  logic        run_dir_valid [ND];
  logic [1:0]  run_dir       [ND];
  logic        result_valid  [ND];
  logic [1:0]  result        [ND];
  logic        illegal_cmd   [ND];
  logic        dead          [ND];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    combat_sequencer #(
      .PLAYER_MAX_HP(cfg_pmax(g)),
      .ENEMY_MAX_HP (cfg_emax(g)),
      .PLAYER_DMG   (PDMG),
      .ENEMY_DMG    (EDMG),
      .DMG_RAND_EN  (cfg_rand(g)),
      .RUN_THRESH   (cfg_thresh(g))
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enc_start    (enc_start[g]),
      .cmd_valid    (cmd_valid[g]),
      .cmd_code     (cmd_code[g]),
      .cmd_ready    (cmd_ready[g]),
      .godmode      (godmode[g]),
      .in_combat    (in_combat[g]),
      .move_lock    (move_lock[g]),
      .player_hp    (player_hp[g]),
      .enemy_hp     (enemy_hp[g]),
      .run_failed   (run_failed[g]),
      .run_dir_valid(run_dir_valid[g]),
      .run_dir      (run_dir[g]),
      .result_valid (result_valid[g]),
      .result       (result[g]),
      .illegal_cmd  (illegal_cmd[g]),
      .dead         (dead[g])
    );
  end

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, d, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef enum int {A_PSTRIKE, A_ESTRIKE, A_RUN} act_e;

  logic [15:0] m_lfsr;
  int          m_php   [ND];
  int          m_ehp   [ND];
  bit          m_in    [ND];
  bit          m_dead  [ND];
  int          m_res   [ND];
  int          m_dir   [ND];
  bit          m_rv    [ND];
  bit          m_rf    [ND];
  bit          m_rdv   [ND];
  bit          m_ill   [ND];
  act_e        m_pend  [ND][2];
  int          m_npend [ND];

  function automatic int floor0(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    for (int d = 0; d < ND; d++) begin
      m_php[d] = cfg_pmax(d); m_ehp[d] = 0; m_in[d] = 0; m_dead[d] = 0;
      m_res[d] = 0; m_dir[d] = 0; m_rv[d] = 0; m_rf[d] = 0; m_rdv[d] = 0;
      m_ill[d] = 0; m_npend[d] = 0;
    end
  endtask

  task automatic resolve(input int d, input int res);
    m_res[d] = res; m_rv[d] = 1; m_in[d] = 0; m_npend[d] = 0;
  endtask

  task automatic push(input int d, input act_e a);
    m_pend[d][m_npend[d]] = a;
    m_npend[d]++;
  endtask

  // One clock edge: either the next queued turn action resolves, or a new
  // command / encounter is taken in. Rolls use the pre-edge LFSR value.
  task automatic model_step();
    int   rnd;
    act_e a;
    for (int d = 0; d < ND; d++) begin
      m_rv[d] = 0; m_rf[d] = 0; m_rdv[d] = 0; m_ill[d] = 0;
      rnd = (cfg_rand(d) != 0) ? int'(m_lfsr[1:0]) : 0;
      if (m_npend[d] > 0) begin
        a = m_pend[d][0];
        m_pend[d][0] = m_pend[d][1];
        m_npend[d]--;
        case (a)
          A_PSTRIKE: begin
            m_ehp[d] = floor0(m_ehp[d] - (PDMG + rnd));
            if (m_ehp[d] == 0) resolve(d, 1);
          end
          A_ESTRIKE: begin
            if (!godmode[d]) m_php[d] = floor0(m_php[d] - (EDMG + rnd));
            if (m_php[d] == 0) begin
              m_dead[d] = 1;
              resolve(d, 3);
            end
          end
          default: begin
            if (int'(m_lfsr[3:2]) >= cfg_thresh(d)) begin
              m_dir[d] = int'(m_lfsr[5:4]);
              m_rdv[d] = 1;
              m_ehp[d] = 0;
              resolve(d, 2);
            end else begin
              m_rf[d] = 1;
              push(d, A_ESTRIKE);
            end
          end
        endcase
      end else if (m_in[d]) begin
        if (cmd_valid[d]) begin
          if (cmd_code[d] == 16'd5) begin
            push(d, A_PSTRIKE);
            push(d, A_ESTRIKE);
          end else if (cmd_code[d] == 16'd6) begin
            push(d, A_RUN);
          end else begin
            m_ill[d] = 1;
          end
        end
      end else if (!m_dead[d] && enc_start[d]) begin
        m_ehp[d] = cfg_emax(d);
        m_in[d]  = 1;
      end
    end
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Every cycle out of reset, every output of every instance against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int d = 0; d < ND; d++) begin
          check("player_hp",     d, 32'(player_hp[d]),     32'(m_php[d]));
          check("enemy_hp",      d, 32'(enemy_hp[d]),      32'(m_ehp[d]));
          check("in_combat",     d, 32'(in_combat[d]),     32'(m_in[d]));
          check("move_lock",     d, 32'(move_lock[d]),     32'(m_in[d] | m_dead[d]));
          check("dead",          d, 32'(dead[d]),          32'(m_dead[d]));
          check("cmd_ready",     d, 32'(cmd_ready[d]),     32'(m_in[d] && m_npend[d] == 0));
          check("result",        d, 32'(result[d]),        32'(m_res[d]));
          check("result_valid",  d, 32'(result_valid[d]),  32'(m_rv[d]));
          check("run_failed",    d, 32'(run_failed[d]),    32'(m_rf[d]));
          check("run_dir_valid", d, 32'(run_dir_valid[d]), 32'(m_rdv[d]));
          check("run_dir",       d, 32'(run_dir[d]),       32'(m_dir[d]));
          check("illegal_cmd",   d, 32'(illegal_cmd[d]),   32'(m_ill[d]));
        end
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_enc(input int d);
    enc_start[d] = 1'b1;
    tick();
    enc_start[d] = 1'b0;
  endtask

  // Returns just after the edge that accepts the command (edge N).
  task automatic send_cmd(input int d, input logic [15:0] code);
    int n;
    n = 0;
    while (cmd_ready[d] !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", d, 32'(cmd_ready[d]), 1);
    cmd_valid[d] = 1'b1;
    cmd_code[d]  = code;
    tick();
    cmd_valid[d] = 1'b0;
    cmd_code[d]  = 16'd0;
  endtask

  task automatic check_reset_values();
    for (int d = 0; d < ND; d++) begin
      check("rst_player_hp", d, 32'(player_hp[d]),    cfg_pmax(d));
      check("rst_enemy_hp",  d, 32'(enemy_hp[d]),     0);
      check("rst_in_combat", d, 32'(in_combat[d]),    0);
      check("rst_move_lock", d, 32'(move_lock[d]),    0);
      check("rst_dead",      d, 32'(dead[d]),         0);
      check("rst_cmd_ready", d, 32'(cmd_ready[d]),    0);
      check("rst_result",    d, 32'(result[d]),       0);
      check("rst_run_dir",   d, 32'(run_dir[d]),      0);
      check("rst_pulses",    d, 32'({result_valid[d], run_failed[d], run_dir_valid[d], illegal_cmd[d]}), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      enc_start[d] = 1'b0; cmd_valid[d] = 1'b0; cmd_code[d] = 16'd0; godmode[d] = 1'b0;
    end
    repeat (2) tick();
    check_reset_values();
    rst_n = 1'b1;
    tick();

    // Win: fixed damage against a 20 HP enemy.
    start_enc(0);
    check("t1_enemy_loaded", 0, 32'(enemy_hp[0]), 20);
    send_cmd(0, 16'd5);
    tick();
    check("t1_enemy_n1", 0, 32'(enemy_hp[0]), 10);
    check("t1_player_n1", 0, 32'(player_hp[0]), 100);
    tick();
    check("t1_player_n2", 0, 32'(player_hp[0]), 92);
    check("t1_ready_back", 0, 32'(cmd_ready[0]), 1);
    send_cmd(0, 16'd5);
    tick();
    check("t1_enemy_dead", 0, 32'(enemy_hp[0]), 0);
    check("t1_result", 0, 32'(result[0]), 1);
    check("t1_result_valid", 0, 32'(result_valid[0]), 1);
    check("t1_in_combat", 0, 32'(in_combat[0]), 0);
    tick();
    check("t1_rv_pulse_end", 0, 32'(result_valid[0]), 0);
    check("t1_player_kept", 0, 32'(player_hp[0]), 92);
    check("t1_result_held", 0, 32'(result[0]), 1);

    // Death: 16 HP player takes two 8-point strikes.
    start_enc(1);
    send_cmd(1, 16'd5);
    tick();
    tick();
    check("t2_player_8", 1, 32'(player_hp[1]), 8);
    send_cmd(1, 16'd5);
    tick();
    check("t2_enemy_30", 1, 32'(enemy_hp[1]), 30);
    tick();
    check("t2_player_0", 1, 32'(player_hp[1]), 0);
    check("t2_result", 1, 32'(result[1]), 3);
    check("t2_result_valid", 1, 32'(result_valid[1]), 1);
    check("t2_dead", 1, 32'(dead[1]), 1);
    check("t2_move_lock", 1, 32'(move_lock[1]), 1);
    check("t2_in_combat", 1, 32'(in_combat[1]), 0);
    enc_start[1] = 1'b1; cmd_valid[1] = 1'b1; cmd_code[1] = 16'd5;
    repeat (4) tick();
    check("t2_dead_ready", 1, 32'(cmd_ready[1]), 0);
    check("t2_dead_enemy", 1, 32'(enemy_hp[1]), 30);
    check("t2_dead_in_combat", 1, 32'(in_combat[1]), 0);
    check("t2_dead_sticky", 1, 32'(dead[1]), 1);
    enc_start[1] = 1'b0; cmd_valid[1] = 1'b0; cmd_code[1] = 16'd0;

    // Random damage, then a guaranteed escape.
    start_enc(2);
    send_cmd(2, 16'd5);
    tick();
    tick();
    check("t3_player_range", 2, 32'(player_hp[2] >= 16'd89 && player_hp[2] <= 16'd92), 1);
    send_cmd(2, 16'd6);
    tick();
    check("t3_run_dir_valid", 2, 32'(run_dir_valid[2]), 1);
    check("t3_result", 2, 32'(result[2]), 2);
    check("t3_result_valid", 2, 32'(result_valid[2]), 1);
    check("t3_enemy_zero", 2, 32'(enemy_hp[2]), 0);
    check("t3_in_combat", 2, 32'(in_combat[2]), 0);
    tick();
    check("t3_rdv_pulse_end", 2, 32'(run_dir_valid[2]), 0);

    // Godmode attacks, illegal code, failed run.
    godmode[3] = 1'b1;
    start_enc(3);
    for (int i = 1; i <= 3; i++) begin
      send_cmd(3, 16'd5);
      tick();
      check("t4_enemy_step", 3, 32'(enemy_hp[3]), 32'(50 - 10 * i));
      tick();
      check("t4_player_god", 3, 32'(player_hp[3]), 100);
    end
    send_cmd(3, 16'd1);
    check("t4_illegal", 3, 32'(illegal_cmd[3]), 1);
    check("t4_illegal_ready", 3, 32'(cmd_ready[3]), 1);
    check("t4_illegal_enemy", 3, 32'(enemy_hp[3]), 20);
    tick();
    check("t4_illegal_end", 3, 32'(illegal_cmd[3]), 0);
    godmode[3] = 1'b0;
    send_cmd(3, 16'd6);
    tick();
    check("t4_run_failed", 3, 32'(run_failed[3]), 1);
    check("t4_player_n1", 3, 32'(player_hp[3]), 100);
    tick();
    check("t4_player_92", 3, 32'(player_hp[3]), 92);
    check("t4_back_wait", 3, 32'(cmd_ready[3]), 1);
    check("t4_still_fight", 3, 32'(in_combat[3]), 1);

    // enc_start during a fight is ignored.
    start_enc(3);
    check("t5_no_reload", 3, 32'(enemy_hp[3]), 20);

    // Asynchronous reset while the enemy strike is in progress.
    send_cmd(3, 16'd5);
    tick();
    check("t5_enemy_10", 3, 32'(enemy_hp[3]), 10);
    #2 rst_n = 1'b0;
    #1;
    check_reset_values();
    tick();
    rst_n = 1'b1;
    tick();
    check("t5_idle_ready", 3, 32'(cmd_ready[3]), 0);
    start_enc(3);
    check("t5_restart_ready", 3, 32'(cmd_ready[3]), 1);
    check("t5_restart_enemy", 3, 32'(enemy_hp[3]), 50);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
